// File: rtl/regfile.sv
// Two-read, one-write register file with a hard-wired zero register and synchronous active-low reset.
// Define REGFILE_BYPASS_EN to forward same-cycle write data onto the read ports.
module regfile #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              w_en,
   input  logic [ADDR_W-1:0] w_addr,
   input  logic [DATA_W-1:0] w_data,
   input  logic [ADDR_W-1:0] rs1_addr,
   input  logic [ADDR_W-1:0] rs2_addr,
   output logic [DATA_W-1:0] rs1_data,
   output logic [DATA_W-1:0] rs2_data
);

   localparam int NUM_REGS = 2**ADDR_W;

   logic [DATA_W-1:0] regs [0:NUM_REGS-1];
   logic              wr_fire;

   // A write only lands when it targets a real register outside reset.
   assign wr_fire = rst_n && w_en && (w_addr != '0);

   // Entry 0 is rewritten with zero every edge so it can never hold anything else.
   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_REGS; i++) begin
         if (!rst_n || i == 0) begin
            regs[i] <= '0;
         end else if (wr_fire && w_addr == ADDR_W'(i)) begin
            regs[i] <= w_data;
         end
      end
   end

   always_comb begin
      rs1_data = '0;
      if (rs1_addr != '0) begin
         rs1_data = regs[rs1_addr];
`ifdef REGFILE_BYPASS_EN
         if (wr_fire && w_addr == rs1_addr) begin
            rs1_data = w_data;
         end
`endif
      end
   end

   always_comb begin
      rs2_data = '0;
      if (rs2_addr != '0) begin
         rs2_data = regs[rs2_addr];
`ifdef REGFILE_BYPASS_EN
         if (wr_fire && w_addr == rs2_addr) begin
            rs2_data = w_data;
         end
`endif
      end
   end

endmodule

// File: tb/tb_regfile.sv
// Self-checking bench for regfile: directed vectors with literal expectations plus an
// array-based reference model compared against both read ports and the storage every negedge.
module tb_regfile;

   logic        clk_tb;
   logic        rst_n;
   logic        w_en;
   logic [4:0]  w_addr;
   logic [31:0] w_data;
   logic [4:0]  rs1_addr;
   logic [4:0]  rs2_addr;
   logic [31:0] rs1_data;
   logic [31:0] rs2_data;

   logic [31:0] model_regs [32];
   logic        check_en;
   int          checks_total;
   int          checks_passed;

   regfile #(.DATA_W(32), .ADDR_W(5)) dut (
      .clk      (clk_tb),
      .rst_n    (rst_n),
      .w_en     (w_en),
      .w_addr   (w_addr),
      .w_data   (w_data),
      .rs1_addr (rs1_addr),
      .rs2_addr (rs2_addr),
      .rs1_data (rs1_data),
      .rs2_data (rs2_data)
   );

   initial begin
      clk_tb = 1'b0;
      forever #5 clk_tb = ~clk_tb;
   end

   // Reference model: reset clears everything, otherwise a qualified write updates one slot.
   always @(posedge clk_tb) begin
      if (!rst_n) begin
         for (int i = 0; i < 32; i++) model_regs[i] = 32'h0;
      end else if (w_en && w_addr != 5'd0) begin
         model_regs[w_addr] = w_data;
      end
   end

   function automatic logic [31:0] exp_read(input logic [4:0] addr);
      if (addr == 5'd0) return 32'h0;
`ifdef REGFILE_BYPASS_EN
      if (rst_n && w_en && w_addr == addr) return w_data;
`endif
      return model_regs[addr];
   endfunction

   task automatic check_output(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
      checks_total++;
      if (actual === expected) begin
         checks_passed++;
      end else begin
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic apply_stimulus(input logic rst, input logic we, input logic [4:0] wa,
                                 input logic [31:0] wd, input logic [4:0] a1,
                                 input logic [4:0] a2);
      @(posedge clk_tb);
      #1;
      rst_n    = rst;
      w_en     = we;
      w_addr   = wa;
      w_data   = wd;
      rs1_addr = a1;
      rs2_addr = a2;
   endtask

   always @(negedge clk_tb) begin
      if (check_en) begin
         int bad;
         check_output("rs1_model", rs1_data, exp_read(rs1_addr));
         check_output("rs2_model", rs2_data, exp_read(rs2_addr));
         bad = 0;
         for (int i = 0; i < 32; i++) begin
            if (dut.regs[i] !== model_regs[i]) bad++;
         end
         check_output("regs_array_mismatches", 32'(bad), 32'h0);
      end
   end

   initial begin
      logic [31:0] rmw_expect;
      checks_total  = 0;
      checks_passed = 0;
      check_en      = 1'b0;
      rst_n         = 1'b0;
      w_en          = 1'b0;
      w_addr        = 5'd0;
      w_data        = 32'h0;
      rs1_addr      = 5'd0;
      rs2_addr      = 5'd0;

      $display("[TB] reset and sweep");
      apply_stimulus(1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd31);
      check_en = 1'b1;
      @(negedge clk_tb);
      check_output("reset_rs1", rs1_data, 32'h0);
      check_output("reset_rs2", rs2_data, 32'h0);
      for (int i = 1; i < 32; i++) begin
         apply_stimulus(1'b1, 1'b0, 5'd0, 32'h0, 5'(i), 5'(31 - i));
         @(negedge clk_tb);
         check_output("reset_sweep_rs1", rs1_data, 32'h0);
         check_output("reset_sweep_rs2", rs2_data, 32'h0);
      end

      $display("[TB] write then read");
      apply_stimulus(1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 5'd0, 5'd0);
      apply_stimulus(1'b1, 1'b0, 5'd0, 32'h0, 5'd5, 5'd5);
      @(negedge clk_tb);
      check_output("wr5_rs1", rs1_data, 32'hDEADBEEF);
      check_output("wr5_rs2", rs2_data, 32'hDEADBEEF);
      check_output("wr5_regs", dut.regs[5], 32'hDEADBEEF);

      $display("[TB] write to x0");
      apply_stimulus(1'b1, 1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0);
      apply_stimulus(1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd5);
      @(negedge clk_tb);
      check_output("x0_rs1", rs1_data, 32'h0);
      check_output("x0_regs", dut.regs[0], 32'h0);
      check_output("x0_other_intact", rs2_data, 32'hDEADBEEF);

      $display("[TB] disabled write");
      apply_stimulus(1'b1, 1'b1, 5'd7, 32'h12345678, 5'd0, 5'd0);
      apply_stimulus(1'b1, 1'b0, 5'd7, 32'hAAAAAAAA, 5'd7, 5'd7);
      apply_stimulus(1'b1, 1'b0, 5'd0, 32'h0, 5'd7, 5'd0);
      @(negedge clk_tb);
      check_output("noen_rs1", rs1_data, 32'h12345678);

      $display("[TB] read during write");
      apply_stimulus(1'b1, 1'b1, 5'd3, 32'h1111, 5'd0, 5'd0);
      apply_stimulus(1'b1, 1'b1, 5'd3, 32'h2222, 5'd3, 5'd0);
      @(negedge clk_tb);
`ifdef REGFILE_BYPASS_EN
      rmw_expect = 32'h2222;
`else
      rmw_expect = 32'h1111;
`endif
      check_output("rdw_before", rs1_data, rmw_expect);
      apply_stimulus(1'b1, 1'b0, 5'd0, 32'h0, 5'd3, 5'd0);
      @(negedge clk_tb);
      check_output("rdw_after", rs1_data, 32'h2222);

      $display("[TB] mid-sequence reset");
      apply_stimulus(1'b0, 1'b1, 5'd9, 32'hCAFE, 5'd5, 5'd9);
      @(negedge clk_tb);
      check_output("rst_during_rs2", rs2_data, 32'h0000CAFE & 32'h0);
      apply_stimulus(1'b1, 1'b0, 5'd0, 32'h0, 5'd5, 5'd9);
      @(negedge clk_tb);
      check_output("rst_clear_rs1", rs1_data, 32'h0);
      check_output("rst_drop_rs2", rs2_data, 32'h0);
      apply_stimulus(1'b1, 1'b1, 5'd9, 32'hBEEF, 5'd0, 5'd0);
      apply_stimulus(1'b1, 1'b0, 5'd0, 32'h0, 5'd9, 5'd3);
      @(negedge clk_tb);
      check_output("resume_rs1", rs1_data, 32'hBEEF);
      check_output("resume_rs2", rs2_data, 32'h0);

      $display("[TB] random traffic");
      for (int n = 0; n < 100; n++) begin
         apply_stimulus(1'b1, ($urandom_range(0, 3) != 0), 5'($urandom_range(0, 31)),
                        $urandom, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
      end

      apply_stimulus(1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
      @(negedge clk_tb);
      #1;
      $display("[TB] %0d/%0d checks passed", checks_passed, checks_total);
      $finish;
   end

endmodule
